// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ valid/ready
// producers. Bursts are kept contiguous, writes are registered, and the FIFO
// acknowledge/overflow responses are monitored into sticky error flags.
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int N_REQ      = 4,
    parameter int IDW        = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_last,
    input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]       fifo_data_in,
    input  logic                        fifo_full,
    input  logic                        fifo_almostfull,
    input  logic                        fifo_wr_ack,
    input  logic                        fifo_overflow,
    output logic [IDW-1:0]              grant_id,
    output logic                        busy,
    output logic                        err_overflow,
    output logic                        err_noack
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                  fifo_wr_en_q, fifo_wr_en_d;
    logic [FIFO_WIDTH-1:0] fifo_data_in_q, fifo_data_in_d;
    logic [IDW-1:0]        grant_id_q, grant_id_d;
    logic                  wr_en_dly_q, wr_en_dly_d;
    logic                  err_overflow_q, err_overflow_d;
    logic                  err_noack_q, err_noack_d;

    logic [FIFO_WIDTH-1:0] beat [N_REQ];
    logic                  can_wr;
    logic                  cand_vld;
    logic [IDW-1:0]        cand;
    logic                  sel_vld;
    logic [IDW-1:0]        sel;
    logic                  accept;

    // (base + off) mod N_REQ, used for the round-robin search and pointer advance
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % N_REQ;
        return IDW'(s);
    endfunction

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign beat[g] = req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
    end

    // Round-robin candidate: scan downward so the last hit is the first valid at/after rr_ptr
    always_comb begin
        cand_vld = 1'b0;
        cand     = rr_ptr_q;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_inc(rr_ptr_q, k)]) begin
                cand_vld = 1'b1;
                cand     = wrap_inc(rr_ptr_q, k);
            end
        end
    end

    // Grant selection, ready generation and next-state for FSM, write port and error flags
    always_comb begin
        // A write already in flight will take the last free slot.
        can_wr  = !fifo_full && !(fifo_almostfull && fifo_wr_en_q);
        sel     = (state_q == BURST) ? grant_id_q : cand;
        sel_vld = (state_q == BURST) || cand_vld;

        req_ready = '0;
        if (!rst && sel_vld && can_wr) begin
            req_ready[sel] = 1'b1;
        end
        accept = |(req_valid & req_ready);

        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        fifo_wr_en_d   = accept;
        fifo_data_in_d = fifo_data_in_q;
        grant_id_d     = grant_id_q;
        wr_en_dly_d    = fifo_wr_en_q;
        err_overflow_d = err_overflow_q | fifo_overflow;
        err_noack_d    = err_noack_q | (wr_en_dly_q & !fifo_wr_ack);

        if (accept) begin
            fifo_data_in_d = beat[sel];
            grant_id_d     = sel;
            if (req_last[sel]) begin
                state_d  = IDLE;
                rr_ptr_d = wrap_inc(sel, 1);
            end else begin
                state_d  = BURST;
            end
        end
    end

    // State and output registers; reset abandons any burst and issues no write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            fifo_wr_en_q   <= 1'b0;
            fifo_data_in_q <= '0;
            grant_id_q     <= '0;
            wr_en_dly_q    <= 1'b0;
            err_overflow_q <= 1'b0;
            err_noack_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            fifo_wr_en_q   <= fifo_wr_en_d;
            fifo_data_in_q <= fifo_data_in_d;
            grant_id_q     <= grant_id_d;
            wr_en_dly_q    <= wr_en_dly_d;
            err_overflow_q <= err_overflow_d;
            err_noack_q    <= err_noack_d;
        end
    end

    assign fifo_wr_en   = fifo_wr_en_q;
    assign fifo_data_in = fifo_data_in_q;
    assign grant_id     = grant_id_q;
    assign busy         = (state_q == BURST);
    assign err_overflow = err_overflow_q;
    assign err_noack    = err_noack_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-driven producers, a depth-8 FIFO stub, and a
// behavioural arbiter model checked every cycle, plus directed literal checks.
module tb_fifo_wr_arbiter;
    localparam int W     = 16;
    localparam int N     = 4;
    localparam int IDW   = 2;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [N*W-1:0] req_data;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
    logic [IDW-1:0] grant_id;
    logic           busy, err_overflow, err_noack;

    fifo_wr_arbiter #(.FIFO_WIDTH(W), .N_REQ(N), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
        .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
        .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
        .grant_id(grant_id), .busy(busy),
        .err_overflow(err_overflow), .err_noack(err_noack)
    );

    // FIFO stub: occupancy counter with ack/overflow one cycle after the write edge
    int   fcnt = 0;
    logic ack_q = 1'b0, ovf_q = 1'b0;
    logic rd_en, ack_kill, ovf_inj;
    always @(posedge clk) begin
        if (rst) begin
            fcnt  <= 0;
            ack_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            ack_q <= (fifo_wr_en === 1'b1) && fcnt < DEPTH;
            ovf_q <= (fifo_wr_en === 1'b1) && fcnt >= DEPTH;
            fcnt  <= fcnt + (((fifo_wr_en === 1'b1) && fcnt < DEPTH) ? 1 : 0)
                          - ((rd_en && fcnt > 0) ? 1 : 0);
        end
    end
    assign fifo_full       = (fcnt == DEPTH);
    assign fifo_almostfull = (fcnt == DEPTH - 1);
    assign fifo_wr_ack     = ack_q && !ack_kill;
    assign fifo_overflow   = ovf_q || ovf_inj;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model state: owner (-1 = no burst), rr pointer, registered outputs
    int           m_owner = -1, m_rr = 0, m_gid = 0;
    logic         m_wr = 0, m_wr_prev = 0, m_noack = 0, m_ovf = 0;
    logic [W-1:0] m_data = '0;
    logic [N-1:0] acc_mask = '0;
    logic [W-1:0] wlog[$];
    int           wcyc[$];

    // Compare process: check DUT against model, then advance model by one edge
    always @(negedge clk) begin : cmp
        logic         can, acc;
        int           sel;
        logic [N-1:0] er;
        cyc++;
        if (fifo_wr_en === 1'b1) begin
            wlog.push_back(fifo_data_in);
            wcyc.push_back(cyc);
        end
        can = !fifo_full && !(fifo_almostfull && m_wr);
        sel = -1;
        if (!rst) begin
            if (m_owner >= 0) sel = m_owner;
            else for (int k = 0; k < N; k++)
                if (sel < 0 && req_valid[(m_rr + k) % N]) sel = (m_rr + k) % N;
        end
        er  = '0;
        acc = 1'b0;
        if (sel >= 0 && can) begin
            er[sel] = 1'b1;
            acc     = req_valid[sel];
        end
        if (chk_on) begin
            chk("req_ready", req_ready, er);
            chk("fifo_wr_en", fifo_wr_en, m_wr);
            chk("fifo_data_in", fifo_data_in, m_data);
            chk("grant_id", grant_id, m_gid);
            chk("busy", busy, 1'(m_owner >= 0));
            chk("err_noack", err_noack, m_noack);
            chk("err_overflow", err_overflow, m_ovf);
        end
        if (rst) begin
            m_owner = -1; m_rr = 0; m_gid = 0; m_wr = 0; m_wr_prev = 0;
            m_data = '0; m_noack = 0; m_ovf = 0;
            acc_mask = '0;
        end else begin
            m_noack   = m_noack | (m_wr_prev & !fifo_wr_ack);
            m_ovf     = m_ovf | fifo_overflow;
            m_wr_prev = m_wr;
            m_wr      = acc;
            if (acc) begin
                m_data = req_data[sel*W +: W];
                m_gid  = sel;
                if (req_last[sel]) begin
                    m_owner = -1;
                    m_rr    = (sel + 1) % N;
                end else begin
                    m_owner = sel;
                end
            end
            acc_mask = acc ? er : '0;
        end
    end

    // Producers: each presents the head of its beat queue and holds it until accepted
    typedef struct packed { logic [W-1:0] d; logic l; } beat_t;
    beat_t        pq[N][$];
    logic [N-1:0] p_vld;
    bit           gaps;

    task automatic push(input int i, input logic [W-1:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        pq[i].push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i]) begin
                if (pq[i].size() > 0) void'(pq[i].pop_front());
                p_vld[i] = 1'b0;
            end
            if (!p_vld[i] && pq[i].size() > 0 && (!gaps || $urandom_range(2) != 0)) p_vld[i] = 1'b1;
            req_valid[i]       = p_vld[i];
            req_last[i]        = (pq[i].size() > 0) ? pq[i][0].l : 1'b0;
            req_data[i*W +: W] = (pq[i].size() > 0) ? pq[i][0].d : '0;
        end
        #1;
    endtask

    task automatic run_writes(input int n, input int budget, input string nm);
        int t;
        t = 0;
        while (wlog.size() < n && t < budget) begin
            tick();
            t++;
        end
        if (wlog.size() < n) chk({nm, "_timeout"}, wlog.size(), n);
    endtask

    function automatic logic [W-1:0] wl(input int k);
        return (k < wlog.size()) ? wlog[k] : 16'hDEAD;
    endfunction

    initial begin
        logic [W-1:0] exp2 [5];
        logic [W-1:0] exp3 [6];
        int t;
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
        rd_en = 1'b1; ack_kill = 1'b0; ovf_inj = 1'b0; gaps = 0; p_vld = '0;

        // 1: reset held two cycles with every requester valid
        for (int i = 0; i < N; i++) push(i, W'(16'hA0 + i), 1'b1);
        push(0, 16'hA0, 1'b1);
        tick();
        chk_on = 1;
        tick();
        chk("t1_ready", req_ready, 0);
        chk("t1_wr_en", fifo_wr_en, 0);
        chk("t1_grant", grant_id, 0);
        chk("t1_err_ovf", err_overflow, 0);
        chk("t1_err_noack", err_noack, 0);

        // 2: single beats, held continuously -> A0,A1,A2,A3,A0 back to back
        rst = 1'b0;
        wlog.delete(); wcyc.delete();
        run_writes(5, 20, "t2");
        exp2 = '{16'hA0, 16'hA1, 16'hA2, 16'hA3, 16'hA0};
        for (int k = 0; k < 5; k++) chk("t2_data", wl(k), exp2[k]);
        if (wcyc.size() >= 5) chk("t2_consecutive", wcyc[4] - wcyc[0], 4);
        repeat (3) tick();

        // 3: rr_ptr is 1 here; req1 burst wins and stays contiguous, then req2, then req0
        wlog.delete(); wcyc.delete();
        push(0, 16'h20, 1'b1); push(0, 16'h30, 1'b1);
        push(1, 16'h11, 1'b0); push(1, 16'h12, 1'b0); push(1, 16'h13, 1'b1);
        push(2, 16'h22, 1'b1);
        run_writes(6, 30, "t3");
        exp3 = '{16'h11, 16'h12, 16'h13, 16'h22, 16'h20, 16'h30};
        for (int k = 0; k < 6; k++) chk("t3_data", wl(k), exp3[k]);
        if (wcyc.size() >= 3) chk("t3_burst_contig", wcyc[2] - wcyc[0], 2);

        // 4: no reads, req0 streams -> exactly DEPTH writes, ready low while full
        rst = 1'b1; rd_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        wlog.delete(); wcyc.delete();
        for (int k = 0; k < 12; k++) push(0, W'(16'h400 + k), 1'b1);
        repeat (25) tick();
        chk("t4_writes", wlog.size(), DEPTH);
        chk("t4_last_data", wl(7), 16'h407);
        chk("t4_full", fifo_full, 1);
        chk("t4_ready_full", req_ready, 0);
        chk("t4_err_ovf", err_overflow, 0);
        chk("t4_err_noack", err_noack, 0);
        rd_en = 1'b1;
        repeat (20) tick();
        chk("t4_drain", wlog.size(), 12);

        // 5: missing acknowledge -> err_noack two cycles after fifo_wr_en, sticky
        ack_kill = 1'b1;
        push(2, 16'h55, 1'b1);
        t = 0;
        while (fifo_wr_en !== 1'b1 && t < 10) begin tick(); t++; end
        chk("t5_wr_seen", fifo_wr_en, 1);
        chk("t5_noack_0", err_noack, 0);
        tick();
        chk("t5_noack_1", err_noack, 0);
        tick();
        chk("t5_noack_2", err_noack, 1);
        ack_kill = 1'b0;
        repeat (5) tick();
        chk("t5_noack_sticky", err_noack, 1);

        // overflow flag is sticky
        ovf_inj = 1'b1;
        tick();
        ovf_inj = 1'b0;
        chk("ovf_set", err_overflow, 1);
        repeat (3) tick();
        chk("ovf_sticky", err_overflow, 1);

        // 6: reset on beat 2 of a 4-beat burst
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_noack_clr", err_noack, 0);
        chk("t6_ovf_clr", err_overflow, 0);
        wlog.delete(); wcyc.delete();
        push(1, 16'h41, 1'b0); push(1, 16'h42, 1'b0); push(1, 16'h43, 1'b0); push(1, 16'h44, 1'b1);
        t = 0;
        while (pq[1].size() > 2 && t < 20) begin tick(); t++; end
        rst = 1'b1;
        tick();
        for (int i = 0; i < N; i++) pq[i].delete();
        p_vld = '0; req_valid = '0;
        rst = 1'b0;
        chk("t6_no_write", fifo_wr_en, 0);
        chk("t6_busy", busy, 0);
        chk("t6_grant", grant_id, 0);
        chk("t6_pre_writes", wlog.size(), 2);
        push(3, 16'h63, 1'b1); push(0, 16'h60, 1'b1);
        run_writes(4, 20, "t6");
        chk("t6_first_after", wl(2), 16'h60);
        chk("t6_second_after", wl(3), 16'h63);

        // Random phase: bursts of 1..4, valid gaps, varying read rate, rare resets
        gaps = 1;
        for (int c = 0; c < 3000; c++) begin
            rd_en = (c < 1500) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            rst   = ($urandom_range(499) == 0);
            for (int i = 0; i < N; i++) begin
                if (pq[i].size() == 0 && $urandom_range(5) == 0) begin
                    int len;
                    len = $urandom_range(4, 1);
                    for (int b = 0; b < len; b++) push(i, W'($urandom), 1'(b == len - 1));
                end
            end
            tick();
        end
        rst = 1'b0; rd_en = 1'b1;
        repeat (5) tick();
        chk("rand_err_ovf", err_overflow, 0);
        chk("rand_err_noack", err_noack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
